// File: rtl/mw_stage_queue.sv
// Memory/writeback elastic stage: a DEPTH-entry circular buffer whose writeback
// destination, enable and data are resolved when an instruction is enqueued.
module mw_stage_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] insn_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              ovf_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] insn_out,
  output logic [DATA_W-1:0] wdata_out,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic              byp_valid,
  output logic [4:0]        byp_rd,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;

  logic [DATA_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] insn_mem  [DEPTH];
  logic [DATA_W-1:0] wdata_mem [DEPTH];
  logic [4:0]        rd_mem    [DEPTH];
  logic              we_mem    [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] cnt_q;

  logic [4:0]        opcode, rd, aluop;
  logic              dec_we;
  logic [4:0]        dec_rd;
  logic [DATA_W-1:0] dec_wdata;
  logic              push, pop;
  logic              unused_insn_bits;

  assign opcode = insn_in[31:27];
  assign rd     = insn_in[26:22];
  assign aluop  = insn_in[6:2];
  assign unused_insn_bits = ^{insn_in[21:7], insn_in[1:0]};

  // Resolve the architectural writeback once, so the head can drive the register file directly.
  always_comb begin
    dec_we    = 1'b0;
    dec_rd    = rd;
    dec_wdata = wdata_in;
    case (opcode)
      OP_RTYPE: begin
        dec_we = 1'b1;
        if (ovf_in && aluop == ALU_ADD) begin
          dec_rd    = 5'd30;
          dec_wdata = DATA_W'(1);
        end else if (ovf_in && aluop == ALU_SUB) begin
          dec_rd    = 5'd30;
          dec_wdata = DATA_W'(3);
        end
      end
      OP_ADDI: begin
        dec_we = 1'b1;
        if (ovf_in) begin
          dec_rd    = 5'd30;
          dec_wdata = DATA_W'(2);
        end
      end
      OP_LW: dec_we = 1'b1;
      OP_JAL: begin
        dec_we    = 1'b1;
        dec_rd    = 5'd31;
        dec_wdata = pc_in + DATA_W'(1);
      end
      OP_SETX: begin
        dec_we    = 1'b1;
        dec_rd    = 5'd30;
        dec_wdata = DATA_W'(insn_in[26:0]);
      end
      default: dec_we = 1'b0;
    endcase
    if (dec_rd == 5'd0) dec_we = 1'b0;
  end

  // A full queue still accepts when the head leaves in the same cycle.
  assign in_ready  = (cnt_q < FULL_CNT) | out_ready;
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        insn_mem[i]  <= '0;
        wdata_mem[i] <= '0;
        rd_mem[i]    <= '0;
        we_mem[i]    <= 1'b0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        pc_mem[tail]    <= pc_in;
        insn_mem[tail]  <= insn_in;
        wdata_mem[tail] <= dec_wdata;
        rd_mem[tail]    <= dec_rd;
        we_mem[tail]    <= dec_we;
        tail            <= (tail == LAST_PTR) ? '0 : tail + PTR_W'(1);
      end
      if (pop) head <= (head == LAST_PTR) ? '0 : head + PTR_W'(1);
      if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign pc_out    = pc_mem[head];
  assign insn_out  = insn_mem[head];
  assign wdata_out = wdata_mem[head];
  assign wb_rd     = rd_mem[head];
  assign wb_we     = out_valid & we_mem[head];
  assign byp_valid = wb_we;
  assign byp_rd    = wb_rd;
  assign count     = cnt_q;

endmodule

// File: tb/tb_mw_stage_queue.sv
// Directed bench for mw_stage_queue: expected writebacks are queued when an
// instruction is accepted and compared against the head as it is presented.
module tb_mw_stage_queue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush, in_valid, in_ready, ovf_in, out_valid, out_ready;
  logic [31:0] pc_in, insn_in, wdata_in, pc_out, insn_out, wdata_out;
  logic        wb_we, byp_valid;
  logic [4:0]  wb_rd, byp_rd;
  logic [2:0]  count;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] insn;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  mw_stage_queue #(.DATA_W(32), .DEPTH(DEPTH), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .insn_in(insn_in), .wdata_in(wdata_in), .ovf_in(ovf_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .insn_out(insn_out), .wdata_out(wdata_out),
    .wb_we(wb_we), .wb_rd(wb_rd), .byp_valid(byp_valid), .byp_rd(byp_rd),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] aluop);
    return {op, rd, 15'd0, aluop, 2'b00};
  endfunction

  // Head and occupancy against the scoreboard, sampled mid-cycle.
  task automatic check_state(input string tag);
    logic nonempty;
    nonempty = (sb.size() != 0);
    check({tag, ".count"}, 32'(count), 32'(sb.size()));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(nonempty));
    check({tag, ".wb_we"}, 32'(wb_we), 32'(nonempty && sb[0].we));
    check({tag, ".byp_valid"}, 32'(byp_valid), 32'(nonempty && sb[0].we));
    if (nonempty) begin
      check({tag, ".wb_rd"}, 32'(wb_rd), 32'(sb[0].rd));
      check({tag, ".byp_rd"}, 32'(byp_rd), 32'(sb[0].rd));
      check({tag, ".wdata"}, wdata_out, sb[0].wdata);
      check({tag, ".pc"}, pc_out, sb[0].pc);
      check({tag, ".insn"}, insn_out, sb[0].insn);
    end
  endtask

  // One cycle: drive at the falling edge, clock, then compare at the next falling edge.
  task automatic applyStimulus(input string tag, input logic v, input logic [31:0] insn,
                               input logic [31:0] pc, input logic [31:0] wd, input logic ovf,
                               input logic ordy, input logic fl, input logic e_we,
                               input logic [4:0] e_rd, input logic [31:0] e_wd);
    logic rdy_exp;
    exp_t e;
    in_valid = v; insn_in = insn; pc_in = pc; wdata_in = wd; ovf_in = ovf;
    out_ready = ordy; flush = fl;
    rdy_exp = (sb.size() < DEPTH) || ordy;
    #1 check({tag, ".in_ready"}, 32'(in_ready), 32'(rdy_exp));
    @(posedge clk);
    if (fl) sb.delete();
    else begin
      if (ordy && sb.size() != 0) void'(sb.pop_front());
      if (v && rdy_exp) begin
        e.rd = e_rd; e.we = e_we; e.wdata = e_wd; e.pc = pc; e.insn = insn;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic idle(input string tag, input logic ordy);
    applyStimulus(tag, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, ordy, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ovf_in = 1'b0;
    pc_in = '0; insn_in = '0; wdata_in = '0;
    #12;
    @(negedge clk);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.wb_we", 32'(wb_we), 32'd0);
    check("rst.byp_valid", 32'(byp_valid), 32'd0);
    check("rst.wb_rd", 32'(wb_rd), 32'd0);
    check("rst.pc", pc_out, 32'd0);
    check("rst.insn", insn_out, 32'd0);
    check("rst.wdata", wdata_out, 32'd0);
    check("rst.count", 32'(count), 32'd0);
    reset = 1'b1;
    #1 check("rst.in_ready", 32'(in_ready), 32'd1);

    // Writeback resolution, streamed with out_ready high
    applyStimulus("addi_r5", 1, mk(5'b00101, 5'd5, 5'd0), 32'h100, 32'd7, 0, 1, 0, 1, 5'd5, 32'd7);
    applyStimulus("add_ovf", 1, mk(5'b00000, 5'd4, 5'b00000), 32'h101, 32'h99, 1, 1, 0, 1, 5'd30, 32'd1);
    applyStimulus("addi_ovf", 1, mk(5'b00101, 5'd4, 5'd0), 32'h102, 32'h98, 1, 1, 0, 1, 5'd30, 32'd2);
    applyStimulus("sub_ovf", 1, mk(5'b00000, 5'd4, 5'b00001), 32'h103, 32'h97, 1, 1, 0, 1, 5'd30, 32'd3);
    applyStimulus("and_ovf", 1, mk(5'b00000, 5'd6, 5'b00010), 32'h104, 32'h55, 1, 1, 0, 1, 5'd6, 32'h55);
    applyStimulus("lw_r7", 1, mk(5'b01000, 5'd7, 5'd0), 32'h105, 32'hdead, 0, 1, 0, 1, 5'd7, 32'hdead);
    applyStimulus("jal", 1, {5'b00011, 27'h0000abc}, 32'h10, 32'h5, 0, 1, 0, 1, 5'd31, 32'h11);
    applyStimulus("jal_wrap", 1, {5'b00011, 27'h0000001}, 32'hffffffff, 32'h5, 0, 1, 0, 1, 5'd31, 32'h0);
    applyStimulus("setx", 1, {5'b10101, 27'h123}, 32'h106, 32'h44, 0, 1, 0, 1, 5'd30, 32'h123);
    applyStimulus("add_r0", 1, mk(5'b00000, 5'd0, 5'd0), 32'h107, 32'h66, 0, 1, 0, 0, 5'd0, 32'h66);
    applyStimulus("add_r0_ovf", 1, mk(5'b00000, 5'd0, 5'd0), 32'h108, 32'h66, 1, 1, 0, 1, 5'd30, 32'd1);
    applyStimulus("sw", 1, mk(5'b00111, 5'd9, 5'd0), 32'h109, 32'h77, 0, 1, 0, 0, 5'd9, 32'h77);
    idle("drain0", 1);

    // Fill with out_ready low, then stream through a full queue
    applyStimulus("fill1", 1, mk(5'b01000, 5'd1, 5'd0), 32'h200, 32'ha1, 0, 0, 0, 1, 5'd1, 32'ha1);
    applyStimulus("fill2", 1, mk(5'b01000, 5'd2, 5'd0), 32'h201, 32'ha2, 0, 0, 0, 1, 5'd2, 32'ha2);
    applyStimulus("fill3", 1, mk(5'b01000, 5'd3, 5'd0), 32'h202, 32'ha3, 0, 0, 0, 1, 5'd3, 32'ha3);
    for (int i = 0; i < 5; i++)
      applyStimulus($sformatf("stream%0d", i), 1, mk(5'b01000, 5'(10 + i), 5'd0), 32'h300 + 32'(i),
                    32'hb0 + 32'(i), 0, 1, 0, 1, 5'(10 + i), 32'hb0 + 32'(i));
    idle("drain1", 1);
    idle("drain2", 1);
    idle("drain3", 1);

    // Flush while full overrides the concurrent push
    applyStimulus("ffill1", 1, mk(5'b00101, 5'd8, 5'd0), 32'h400, 32'hc1, 0, 0, 0, 1, 5'd8, 32'hc1);
    applyStimulus("ffill2", 1, mk(5'b00101, 5'd9, 5'd0), 32'h401, 32'hc2, 0, 0, 0, 1, 5'd9, 32'hc2);
    applyStimulus("flush", 1, mk(5'b00101, 5'd11, 5'd0), 32'h402, 32'hc3, 0, 0, 1, 1, 5'd11, 32'hc3);
    applyStimulus("post_flush", 1, mk(5'b00101, 5'd12, 5'd0), 32'h403, 32'hc4, 0, 0, 0, 1, 5'd12, 32'hc4);
    applyStimulus("post_flush2", 1, mk(5'b00101, 5'd13, 5'd0), 32'h404, 32'hc5, 0, 1, 0, 1, 5'd13, 32'hc5);
    idle("drain4", 1);

    // Asynchronous reset with one entry resident
    applyStimulus("pre_rst", 1, mk(5'b00101, 5'd14, 5'd0), 32'h500, 32'hd1, 0, 0, 0, 1, 5'd14, 32'hd1);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst.out_valid", 32'(out_valid), 32'd0);
    check("arst.wb_we", 32'(wb_we), 32'd0);
    check("arst.count", 32'(count), 32'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    idle("post_rst", 0);
    applyStimulus("after_rst", 1, mk(5'b00101, 5'd15, 5'd0), 32'h600, 32'he1, 0, 0, 0, 1, 5'd15, 32'he1);
    idle("final_drain", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
